// File: rtl/gravsim_pkg.sv
// rtl/gravsim_pkg.sv - shared scheduler state type and datafile word map for GravSim
package gravsim_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOST,
    START,
    WAIT_DONE,
    RELEASE
  } sched_state_t;

  localparam int DATAFILE_DEPTH = 113;
  localparam int DF_ADDR_W      = 7;
  localparam int MAX_BODIES     = 9;

  // Scalar words first, then one MAX_BODIES-long array per body attribute.
  localparam int DF_OFF_G     = 0;
  localparam int DF_OFF_NUM   = 1;
  localparam int DF_OFF_START = 2;
  localparam int DF_OFF_DONE  = 3;
  localparam int DF_OFF_MASS  = 4;
  localparam int DF_OFF_RAD   = DF_OFF_MASS  + MAX_BODIES;
  localparam int DF_OFF_POS_X = DF_OFF_RAD   + MAX_BODIES;
  localparam int DF_OFF_POS_Y = DF_OFF_POS_X + MAX_BODIES;
  localparam int DF_OFF_POS_Z = DF_OFF_POS_Y + MAX_BODIES;
  localparam int DF_OFF_VEL_X = DF_OFF_POS_Z + MAX_BODIES;
  localparam int DF_OFF_VEL_Y = DF_OFF_VEL_X + MAX_BODIES;
  localparam int DF_OFF_VEL_Z = DF_OFF_VEL_Y + MAX_BODIES;
  localparam int DF_OFF_ACC_X = DF_OFF_VEL_Z + MAX_BODIES;
  localparam int DF_OFF_ACC_Y = DF_OFF_ACC_X + MAX_BODIES;
  localparam int DF_OFF_ACC_Z = DF_OFF_ACC_Y + MAX_BODIES;

endpackage

// File: rtl/sched_watchdog.sv
// rtl/sched_watchdog.sv - loadable up-counter with clear, enable and terminal-count flag
module sched_watchdog #(
  parameter int          W        = 13,
  parameter logic [W-1:0] TERMINAL = '1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr_i)       count_d = '0;
    else if (load_i) count_d = load_val_i;
    else if (en_i)   count_d = count_q + W'(1);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) count_q <= '0;
    else         count_q <= count_d;
  end

  assign tc_o = (count_q == TERMINAL);

endmodule

// File: rtl/gravsim_step_scheduler.sv
// rtl/gravsim_step_scheduler.sv - timestep scheduler: step handshakes, watchdog recovery and
// host/datafile arbitration so host writes never overlap a running step.
module gravsim_step_scheduler
  import gravsim_pkg::*;
#(
  parameter int DEPTH          = DATAFILE_DEPTH,
  parameter int ADDR_W         = 7,
  parameter int TIMEOUT_CYCLES = 4096,
  parameter int CNT_W          = 32
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              RUN,
  input  logic              FRAME_TICK,
  input  logic              STEP_ONCE,
  output logic              FSM_START,
  input  logic              FSM_DONE,
  output logic              FSM_RST,
  input  logic              HOST_REQ,
  input  logic              HOST_WE,
  input  logic [ADDR_W-1:0] HOST_ADDR,
  input  logic [31:0]       HOST_WDATA,
  output logic              HOST_ACK,
  output logic              HOST_ERR,
  output logic              DF_WE,
  output logic [ADDR_W-1:0] DF_ADDR,
  output logic [31:0]       DF_WDATA,
  output logic              BUSY,
  output logic [CNT_W-1:0]  STEP_COUNT,
  output logic [15:0]       OVERRUN_COUNT,
  output logic              TIMEOUT_ERR,
  input  logic              CLR_ERR
);

  localparam int              WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  sched_state_t      state_q, state_d;
  logic              pending_q, pending_d;
  logic              start_q, frst_q, ack_q, herr_q, we_q, busy_q, terr_q, terr_d;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [CNT_W-1:0]  step_q, step_d;
  logic [15:0]       ovr_q, ovr_d;
  logic              req, overrun, step_done, timeout_fire, wd_tc, wd_clr, wd_en;
  logic              addr_ok, host_hit, host_wr;

  always_comb begin
    req          = (RUN & FRAME_TICK) | STEP_ONCE;
    step_done    = (state_q == WAIT_DONE) & FSM_DONE;
    timeout_fire = (state_q == WAIT_DONE) & ~FSM_DONE & wd_tc;
    // START consumes the pending slot, so a request landing there is latched, not dropped.
    overrun      = req & pending_q & (state_q != START);
    pending_d    = req | (pending_q & (state_q != START));
    wd_clr       = (state_q == START);
    wd_en        = (state_q == WAIT_DONE);
    addr_ok      = ({1'b0, HOST_ADDR} < DEPTH_L);
    host_hit     = (state_q == HOST);
    host_wr      = host_hit & addr_ok & HOST_WE;

    step_d = step_q;
    if (step_done) step_d = step_q + CNT_W'(1);
    ovr_d = CLR_ERR ? 16'h0000 : ovr_q;
    if (overrun && ovr_q != 16'hFFFF) ovr_d = ovr_q + 16'd1;
    terr_d = timeout_fire | (terr_q & ~CLR_ERR);

    state_d = state_q;
    unique case (state_q)
      // ack_q guard stops a held request from being granted twice back to back.
      IDLE:      if (pending_q || req)      state_d = START;
                 else if (HOST_REQ && !ack_q) state_d = HOST;
      HOST:      state_d = IDLE;
      START:     state_d = WAIT_DONE;
      WAIT_DONE: if (step_done || timeout_fire) state_d = RELEASE;
      RELEASE:   if (!FSM_DONE) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  sched_watchdog #(.W(WD_W), .TERMINAL(WD_LAST)) u_watchdog (
    .clk_i      (CLK),
    .rst_ni     (RESET_N),
    .clr_i      (wd_clr),
    .en_i       (wd_en),
    .load_i     (1'b0),
    .load_val_i ({WD_W{1'b0}}),
    .tc_o       (wd_tc)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q   <= IDLE;
      pending_q <= 1'b0;
      start_q   <= 1'b0;
      frst_q    <= 1'b0;
      ack_q     <= 1'b0;
      herr_q    <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      busy_q    <= 1'b0;
      step_q    <= '0;
      ovr_q     <= '0;
      terr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      start_q   <= (state_d == START) || (state_d == WAIT_DONE);
      busy_q    <= (state_d != IDLE);
      frst_q    <= timeout_fire;
      ack_q     <= host_hit;
      herr_q    <= host_hit & ~addr_ok;
      we_q      <= host_wr;
      if (host_wr) begin
        addr_q  <= HOST_ADDR;
        wdata_q <= HOST_WDATA;
      end
      step_q    <= step_d;
      ovr_q     <= ovr_d;
      terr_q    <= terr_d;
    end
  end

  assign FSM_START     = start_q;
  assign FSM_RST       = frst_q;
  assign HOST_ACK      = ack_q;
  assign HOST_ERR      = herr_q;
  assign DF_WE         = we_q;
  assign DF_ADDR       = addr_q;
  assign DF_WDATA      = wdata_q;
  assign BUSY          = busy_q;
  assign STEP_COUNT    = step_q;
  assign OVERRUN_COUNT = ovr_q;
  assign TIMEOUT_ERR   = terr_q;

endmodule

// File: tb/tb_gravsim_step_scheduler.sv
// tb/tb_gravsim_step_scheduler.sv - self-checking bench for gravsim_step_scheduler
module tb_gravsim_step_scheduler;

  localparam int TO = 128;

  logic        CLK = 1'b0;
  logic        RESET_N, RUN, FRAME_TICK, STEP_ONCE, FSM_DONE, HOST_REQ, HOST_WE, CLR_ERR;
  logic [6:0]  HOST_ADDR;
  logic [31:0] HOST_WDATA;
  logic        FSM_START, FSM_RST, HOST_ACK, HOST_ERR, DF_WE, BUSY, TIMEOUT_ERR;
  logic [6:0]  DF_ADDR;
  logic [31:0] DF_WDATA, STEP_COUNT;
  logic [15:0] OVERRUN_COUNT;

  gravsim_step_scheduler #(.TIMEOUT_CYCLES(TO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .RUN(RUN), .FRAME_TICK(FRAME_TICK), .STEP_ONCE(STEP_ONCE),
    .FSM_START(FSM_START), .FSM_DONE(FSM_DONE), .FSM_RST(FSM_RST), .HOST_REQ(HOST_REQ),
    .HOST_WE(HOST_WE), .HOST_ADDR(HOST_ADDR), .HOST_WDATA(HOST_WDATA), .HOST_ACK(HOST_ACK),
    .HOST_ERR(HOST_ERR), .DF_WE(DF_WE), .DF_ADDR(DF_ADDR), .DF_WDATA(DF_WDATA), .BUSY(BUSY),
    .STEP_COUNT(STEP_COUNT), .OVERRUN_COUNT(OVERRUN_COUNT), .TIMEOUT_ERR(TIMEOUT_ERR),
    .CLR_ERR(CLR_ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0, passes = 0;
  int cyc_n = 0, hi = 0, lat = 50, start_cycles = 0, rise_at = 0, fall_at = 0;
  int rst_pulses = 0, rst_at = 0, acks = 0, ack_at = 0, viol = 0;
  bit done_en = 1, prev_start = 0;
  logic        ack_err, ack_we;
  logic [6:0]  ack_addr;
  logic [31:0] ack_wdata;
  int exp_steps = 0, exp_ovr = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // One clock; also plays the FSM (DONE lat cycles after START) and logs host/rst pulses.
  task automatic cyc();
    @(posedge CLK);
    #1;
    cyc_n++;
    if (FSM_START) begin
      if (hi == 0) rise_at = cyc_n;
      hi++;
      start_cycles++;
      if (done_en && hi >= lat) FSM_DONE = 1'b1;
    end else begin
      hi = 0;
      FSM_DONE = 1'b0;
    end
    if (prev_start && !FSM_START) fall_at = cyc_n;
    prev_start = FSM_START;
    if (FSM_RST) begin rst_pulses++; rst_at = cyc_n; end
    if (DF_WE && FSM_START) viol++;
    if (HOST_ACK) begin
      acks++; ack_at = cyc_n;
      ack_err = HOST_ERR; ack_we = DF_WE; ack_addr = DF_ADDR; ack_wdata = DF_WDATA;
    end
  endtask

  task automatic wait_idle();
    int quiet;
    quiet = 0;
    for (int i = 0; i < 3000 && quiet < 3; i++) begin
      cyc();
      quiet = BUSY ? 0 : quiet + 1;
    end
    chk("wait_idle_bound", 64'(quiet >= 3), 64'd1);
  endtask

  task automatic wait_ack();
    int a0;
    a0 = acks;
    for (int i = 0; i < 1000 && acks == a0; i++) cyc();
    HOST_REQ = 1'b0;
    chk("wait_ack_bound", 64'(acks != a0), 64'd1);
  endtask

  task automatic host(input bit we, input logic [6:0] a, input logic [31:0] d, output int l);
    int n0;
    HOST_WE = we; HOST_ADDR = a; HOST_WDATA = d; HOST_REQ = 1'b1;
    n0 = cyc_n;
    wait_ack();
    l = ack_at - n0;
  endtask

  // Offset 0 launches the step; later offsets are FRAME_TICK pulses inside the same step.
  task automatic run_ticks(input int offs[$], input bit first_once);
    int mx;
    mx = 0;
    foreach (offs[q]) if (offs[q] > mx) mx = offs[q];
    for (int j = 0; j <= mx; j++) begin
      FRAME_TICK = 1'b0; STEP_ONCE = 1'b0;
      if (j == 0) begin
        if (first_once) STEP_ONCE = 1'b1; else FRAME_TICK = 1'b1;
      end else foreach (offs[q]) if (offs[q] == j) FRAME_TICK = 1'b1;
      cyc();
    end
    FRAME_TICK = 1'b0; STEP_ONCE = 1'b0;
  endtask

  // A step with k in-flight requests: one more step if k>0, k-1 dropped.
  function automatic void model_step(input int k);
    exp_steps += 1 + ((k > 0) ? 1 : 0);
    exp_ovr   += (k > 1) ? k - 1 : 0;
  endfunction

  initial begin
    #900000;
    $display("FAIL global_time_limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    int offs[$];
    int hl, L, k, o, s0, r0;
    bit dup, rb, we;
    logic [6:0]  a;
    logic [31:0] d;

    RESET_N = 0; RUN = 0; FRAME_TICK = 0; STEP_ONCE = 0; FSM_DONE = 0; HOST_REQ = 0;
    HOST_WE = 0; HOST_ADDR = '0; HOST_WDATA = '0; CLR_ERR = 0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_outputs", {FSM_START, FSM_RST, HOST_ACK, HOST_ERR, DF_WE, BUSY, TIMEOUT_ERR}, 0);
    chk("rst_df", {DF_ADDR, DF_WDATA}, 0);
    chk("rst_counts", {STEP_COUNT, OVERRUN_COUNT}, 0);
    #3 RESET_N = 1;
    repeat (2) cyc();

    // normal 50-cycle step
    RUN = 1; lat = 50; start_cycles = 0;
    offs = {0};
    run_ticks(offs, 0);
    chk("normal_start_rise", FSM_START, 1);
    wait_idle();
    model_step(0);
    chk("normal_start_len", start_cycles, 50);
    chk("normal_step_count", STEP_COUNT, exp_steps);
    chk("normal_busy_low", BUSY, 0);

    // ticks at 0/10/20 during a 100-cycle step
    lat = 100;
    offs = {0, 10, 20};
    run_ticks(offs, 0);
    wait_idle();
    model_step(2);
    chk("overrun_count", OVERRUN_COUNT, exp_ovr);
    chk("overrun_steps", STEP_COUNT, exp_steps);

    // randomized rounds: random length, trigger source, in-step ticks and an idle host access
    for (int r = 0; r < 10; r++) begin
      L = $urandom_range(60, 10); lat = L;
      k = $urandom_range(3, 0);
      rb = 1'($urandom_range(1, 0));
      offs = {0};
      for (int t = 0; t < 50 && offs.size() < k + 1; t++) begin
        o = $urandom_range(L - 1, 2);
        dup = 0;
        foreach (offs[q]) if (offs[q] == o) dup = 1;
        if (!dup) offs.push_back(o);
      end
      RUN = rb;
      run_ticks(offs, !rb);
      wait_idle();
      RUN = 1;
      model_step(rb ? offs.size() - 1 : 0);
      chk("rand_steps", STEP_COUNT, exp_steps);
      chk("rand_overrun", OVERRUN_COUNT, exp_ovr);
      we = 1'($urandom_range(1, 0)); a = 7'($urandom_range(127, 0)); d = $urandom;
      host(we, a, d, hl);
      chk("rand_host_lat", hl, 2);
      chk("rand_host_err", ack_err, (a >= 7'd113));
      chk("rand_host_we", ack_we, we && (a < 7'd113));
      if (we && a < 7'd113) chk("rand_host_data", {ack_addr, ack_wdata}, {a, d});
    end

    // host write held off by a running step
    lat = 30;
    offs = {0};
    run_ticks(offs, 0);
    repeat (5) cyc();
    host(1, 7'd54, 32'h3F800000, hl);
    model_step(0);
    chk("midstep_ack_after_release", 64'((ack_at > fall_at) && (ack_at - fall_at <= 3)), 64'd1);
    chk("midstep_df", {ack_we, ack_addr, ack_wdata}, {1'b1, 7'd54, 32'h3F800000});
    wait_idle();

    // tick and host request in the same idle cycle: step wins
    lat = 20;
    HOST_WE = 1; HOST_ADDR = 7'd112; HOST_WDATA = 32'hCAFE0112; HOST_REQ = 1;
    FRAME_TICK = 1;
    cyc();
    FRAME_TICK = 0;
    chk("sametick_start_first", {FSM_START, HOST_ACK}, 2'b10);
    wait_ack();
    model_step(0);
    chk("sametick_ack_after_step", 64'(ack_at > fall_at), 64'd1);
    chk("sametick_df", {ack_err, ack_we, ack_addr, ack_wdata}, {1'b0, 1'b1, 7'd112, 32'hCAFE0112});
    wait_idle();

    // out-of-range addresses
    host(1, 7'd120, 32'h12345678, hl);
    chk("badaddr", {ack_err, ack_we}, 2'b10);
    host(1, 7'd113, 32'h0, hl);
    chk("badaddr_113", {ack_err, ack_we}, 2'b10);
    host(0, 7'd10, 32'h0, hl);
    chk("read_ok", {ack_err, ack_we}, 2'b00);

    // DONE on the very cycle the watchdog would fire: completion, no error
    lat = TO + 1; r0 = rst_pulses;
    offs = {0};
    run_ticks(offs, 0);
    wait_idle();
    model_step(0);
    chk("wd_boundary_steps", STEP_COUNT, exp_steps);
    chk("wd_boundary_noerr", {TIMEOUT_ERR, 64'(rst_pulses - r0)}, 0);

    // FSM never finishes
    done_en = 0; r0 = rst_pulses; s0 = exp_steps;
    offs = {0};
    run_ticks(offs, 0);
    wait_idle();
    chk("wd_rst_pulses", rst_pulses - r0, 1);
    chk("wd_rst_timing", rst_at - rise_at, TO + 1);
    chk("wd_err_set", TIMEOUT_ERR, 1);
    chk("wd_steps_unchanged", STEP_COUNT, s0);
    repeat (5) cyc();
    chk("wd_err_sticky", TIMEOUT_ERR, 1);
    CLR_ERR = 1;
    cyc();
    CLR_ERR = 0;
    exp_ovr = 0;
    chk("clr_err", {TIMEOUT_ERR, OVERRUN_COUNT}, 0);
    done_en = 1;

    // reset in the middle of WAIT_DONE
    lat = 40;
    offs = {0, 2, 4};
    run_ticks(offs, 0);
    repeat (6) cyc();
    chk("pre_reset_overrun", OVERRUN_COUNT, 1);
    #2 RESET_N = 0;
    #1;
    chk("reset_wait_outputs", {FSM_START, BUSY, TIMEOUT_ERR}, 0);
    chk("reset_wait_counts", {STEP_COUNT, OVERRUN_COUNT}, 0);
    FSM_DONE = 0;
    #3 RESET_N = 1;
    repeat (2) cyc();

    // reset while the host grant is in flight: no ACK ever appears
    HOST_WE = 1; HOST_ADDR = 7'd5; HOST_WDATA = 32'h55; HOST_REQ = 1;
    cyc();
    r0 = acks;
    #2 RESET_N = 0; HOST_REQ = 0;
    #1 chk("reset_host_noack", {HOST_ACK, DF_WE}, 0);
    #3 RESET_N = 1;
    repeat (3) cyc();
    chk("reset_host_no_late_ack", acks - r0, 0);

    // reset during the ACK/DF_WE cycle
    HOST_REQ = 1;
    cyc(); cyc();
    HOST_REQ = 0;
    chk("ack_cycle_seen", {HOST_ACK, DF_WE}, 2'b11);
    #2 RESET_N = 0;
    #1 chk("reset_ack_drop", {HOST_ACK, DF_WE, DF_ADDR, DF_WDATA}, 0);
    #3 RESET_N = 1;
    repeat (2) cyc();

    chk("no_start_during_df_we", viol, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/gravsim_step_scheduler.md
Name: gravsim_step_scheduler

Overview:
- Timestep controller in front of the GravSim force/integration FSM.
- Turns frame ticks or single-step requests into FSM_START/FSM_DONE handshakes, and runs a watchdog with FSM recovery.
- Arbitrates host (HPS/Avalon-side) access to the shared 113-word datafile, so host writes never collide with a running timestep.
- Sits between the host register interface, the datafile register bank and the FSM.

Parameters:
- DEPTH, 113, number of 32-bit datafile words; host addresses >= DEPTH are rejected.
- ADDR_W, 7, host/datafile address width.
- TIMEOUT_CYCLES, 4096, maximum cycles in WAIT_DONE before the watchdog fires.
- CNT_W, 32, width of STEP_COUNT.

Ports:
- CLK  in  1  system clock.
- RESET_N  in  1  asynchronous, active-low reset.
- RUN  in  1  free-run enable; FRAME_TICK is honoured only while RUN=1.
- FRAME_TICK  in  1  one-cycle pulse per frame (vsync-derived).
- STEP_ONCE  in  1  one-cycle pulse requesting a single step regardless of RUN.
- FSM_START  out  1  level start to the FSM.
- FSM_DONE  in  1  FSM done level.
- FSM_RST  out  1  one-cycle synchronous reset pulse to the FSM on watchdog timeout.
- HOST_REQ  in  1  host access request, held until HOST_ACK.
- HOST_WE  in  1  1 = write, 0 = read; sampled with HOST_REQ.
- HOST_ADDR  in  ADDR_W  host word address.
- HOST_WDATA  in  32  host write data.
- HOST_ACK  out  1  one-cycle grant/complete pulse; the host samples datafile read data in this cycle.
- HOST_ERR  out  1  valid with HOST_ACK; 1 = address out of range.
- DF_WE  out  1  datafile write strobe for host writes.
- DF_ADDR  out  ADDR_W  datafile write address.
- DF_WDATA  out  32  datafile write data.
- BUSY  out  1  1 in any state other than IDLE.
- STEP_COUNT  out  CNT_W  completed steps; wraps modulo 2^CNT_W.
- OVERRUN_COUNT  out  16  ticks dropped because a step was already pending; saturates at 16'hFFFF.
- TIMEOUT_ERR  out  1  sticky watchdog flag.
- CLR_ERR  in  1  clears TIMEOUT_ERR and OVERRUN_COUNT.

Behaviour:
- Reset values: all outputs 0, state IDLE, pending=0, watchdog=0.
- Reset is asynchronous; asserting it mid-step drops FSM_START immediately and aborts any host grant with no ACK.
- pending is set by (RUN & FRAME_TICK) | STEP_ONCE.
- A set request while pending=1 is dropped and increments OVERRUN_COUNT.
- Requests arriving while BUSY with pending=0 are latched as pending.
- States and transitions:
  - IDLE: if pending, go to START; else if HOST_REQ, go to HOST. A pending step beats the host when both are present.
  - HOST (1 cycle), then IDLE:
    - HOST_ACK=1.
    - If HOST_ADDR<DEPTH and HOST_WE=1: DF_WE=1, DF_ADDR=HOST_ADDR, DF_WDATA=HOST_WDATA.
    - If HOST_ADDR>=DEPTH: HOST_ERR=1, DF_WE=0.
  - START: FSM_START=1, clear pending, clear watchdog, go to WAIT_DONE.
  - WAIT_DONE: FSM_START=1, watchdog increments each cycle.
    - If FSM_DONE=1: STEP_COUNT+1, go to RELEASE.
    - Else if watchdog==TIMEOUT_CYCLES-1: TIMEOUT_ERR=1, FSM_RST=1 for this cycle, go to RELEASE.
  - RELEASE: FSM_START=0; go to IDLE once FSM_DONE==0. After a normal completion this is expected the next cycle.
- DONE takes precedence over timeout if both occur in the same cycle; no error is flagged.
- All outputs are registered.
- Host latency from REQ to ACK while IDLE with no pending step is 2 cycles.
- Worst-case host latency is one full step plus 3 cycles.
- FSM_START is never asserted while DF_WE=1.
- Clearing RUN mid-step does not abort the step; an already-latched pending step still runs.
- CLR_ERR in the same cycle as a new overrun or timeout: the set wins.

Decomposition:
- Shared package gravsim_pkg:
  - sched_state_t enum (IDLE, HOST, START, WAIT_DONE, RELEASE).
  - DATAFILE_DEPTH=113.
  - Datafile offset constants (G, NUM, START, DONE, MASS, RAD, POS/VEL/ACC X/Y/Z).
- One sub-module, sched_watchdog: loadable counter with clear, enable and terminal-count output.
- Host datapath registers stay in the top.

Test Plan:
- Normal step:
  - Stimulus: RUN=1, one FRAME_TICK, FSM model raises DONE 50 cycles after START.
  - Response: FSM_START high for exactly 50 cycles plus the RELEASE exit, STEP_COUNT=1, BUSY returns to 0.
- Overrun:
  - Stimulus: FRAME_TICK at cycles 0, 10 and 20 while the step lasts 100 cycles.
  - Response: second tick latched, third dropped, OVERRUN_COUNT=1, STEP_COUNT=2 at the end.
- Host arbitration:
  - Stimulus: HOST_REQ write addr 7'd54, data 32'h3F800000 asserted mid-step.
  - Response: no ACK until after RELEASE, then ACK with DF_WE=1, DF_ADDR=54, DF_WDATA=32'h3F800000. Same-cycle tick plus request in IDLE: step starts first.
- Bad address:
  - Stimulus: host write to addr 7'd120.
  - Response: HOST_ACK=1, HOST_ERR=1, DF_WE=0.
- Watchdog:
  - Stimulus: TIMEOUT_CYCLES=16, FSM never asserts DONE.
  - Response: FSM_RST pulse in cycle 16 of WAIT_DONE, TIMEOUT_ERR=1 sticky, STEP_COUNT unchanged. CLR_ERR then clears the flag.
- Reset:
  - Stimulus: RESET_N low mid-WAIT_DONE and mid-HOST.
  - Response: FSM_START, HOST_ACK and DF_WE fall without a clock edge; all counters read 0.
